// File: rtl/cpu_sequencer_if.sv
// Sequencer-side bus: control inputs from the debug/decoder logic, sequencing status outputs.
interface cpu_sequencer_if #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned WAIT_W      = 2,
  parameter int unsigned CNT_W       = 16
);
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               run;
  logic               step_mode;
  logic               step;
  logic [WAIT_W-1:0]  mem_wait;
  logic [4:0]         inst;
  logic               push;
  logic               pop;
  logic [2:0]         state;
  logic               busy;
  logic               halted;
  logic               paused;
  logic               fault;
  logic               fault_ovf;
  logic [DEPTH_W-1:0] stack_depth;
  logic [CNT_W-1:0]   retired;

  modport master (
    output run, step_mode, step, mem_wait, inst, push, pop,
    input  state, busy, halted, paused, fault, fault_ovf, stack_depth, retired
  );

  modport slave (
    input  run, step_mode, step, mem_wait, inst, push, pop,
    output state, busy, halted, paused, fault, fault_ovf, stack_depth, retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/exec1/exec2 sequencer with memory wait states, STP halt, debug single-step,
// return-stack depth tracking with overflow/underflow trap, and a retired-instruction counter.
module cpu_sequencer #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned WAIT_W      = 2,
  parameter int unsigned CNT_W       = 16
) (
  input logic            clk,
  input logic            rst_n,
  cpu_sequencer_if.slave bus
);
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_FETCH, S_EXEC1, S_EXEC2, S_PAUSE, S_HALT, S_FAULT
  } st_t;

  st_t                st_q, st_d;
  logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
  logic               halt_q, halt_d;
  logic [DEPTH_W-1:0] depth_d;
  logic               ovf_d;
  logic [CNT_W-1:0]   ret_d;
  logic               launch;
  logic               ovf_hit, udf_hit, is_stp;
  logic               unused_inst_lsb;

  assign unused_inst_lsb = bus.inst[0];
  assign is_stp  = (bus.inst[4:1] == 4'b0100);
  assign ovf_hit = bus.push & ~bus.pop & (bus.stack_depth == DEPTH_MAX);
  assign udf_hit = bus.pop & ~bus.push & (bus.stack_depth == '0);

  // Next-state, stack depth, halt flag and counter updates
  always_comb begin
    st_d    = st_q;
    wcnt_d  = wcnt_q;
    halt_d  = halt_q;
    depth_d = bus.stack_depth;
    ovf_d   = bus.fault_ovf;
    ret_d   = bus.retired;
    launch  = 1'b0;
    case (st_q)
      S_IDLE:  launch = bus.run;
      S_WAIT: begin
        if (wcnt_q == WAIT_W'(1)) st_d = S_FETCH;
        wcnt_d = wcnt_q - WAIT_W'(1);
      end
      S_FETCH: st_d = S_EXEC1;
      S_EXEC1: begin
        if (is_stp) halt_d = 1'b1;
        if (ovf_hit || udf_hit) begin
          st_d  = S_FAULT;
          ovf_d = ovf_hit;
        end else begin
          st_d = S_EXEC2;
          if (bus.push && !bus.pop)      depth_d = bus.stack_depth + DEPTH_W'(1);
          else if (bus.pop && !bus.push) depth_d = bus.stack_depth - DEPTH_W'(1);
        end
      end
      S_EXEC2: begin
        ret_d = bus.retired + CNT_W'(1);
        if (halt_q) begin
          st_d   = S_HALT;
          halt_d = 1'b0;
        end else if (bus.step_mode) begin
          st_d = S_PAUSE;
        end else begin
          launch = 1'b1;
        end
      end
      S_PAUSE: launch = bus.step | bus.run;
      S_HALT:  launch = bus.run;
      S_FAULT: st_d = S_FAULT;
      default: st_d = S_IDLE;
    endcase
    // mem_wait is captured only here; later changes affect the next instruction
    if (launch) begin
      if (bus.mem_wait != '0) begin
        st_d   = S_WAIT;
        wcnt_d = bus.mem_wait;
      end else begin
        st_d = S_FETCH;
      end
    end
  end

  // State register with outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q            <= S_IDLE;
      wcnt_q          <= '0;
      halt_q          <= 1'b0;
      bus.state       <= 3'b000;
      bus.busy        <= 1'b0;
      bus.halted      <= 1'b0;
      bus.paused      <= 1'b0;
      bus.fault       <= 1'b0;
      bus.fault_ovf   <= 1'b0;
      bus.stack_depth <= '0;
      bus.retired     <= '0;
    end else begin
      st_q            <= st_d;
      wcnt_q          <= wcnt_d;
      halt_q          <= halt_d;
      bus.state       <= {st_d == S_EXEC2, st_d == S_EXEC1, st_d == S_FETCH};
      bus.busy        <= (st_d == S_WAIT) || (st_d == S_FETCH) ||
                         (st_d == S_EXEC1) || (st_d == S_EXEC2);
      bus.halted      <= (st_d == S_HALT);
      bus.paused      <= (st_d == S_PAUSE);
      bus.fault       <= (st_d == S_FAULT);
      bus.fault_ovf   <= ovf_d;
      bus.stack_depth <= depth_d;
      bus.retired     <= ret_d;
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-position model checked every cycle plus directed literal checks.
module tb_cpu_sequencer;
  localparam int unsigned SD = 4;
  localparam int unsigned WW = 2;
  localparam int unsigned CW = 16;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_HALT  = 3;
  localparam int M_FAULT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.STACK_DEPTH(SD), .WAIT_W(WW), .CNT_W(CW)) bus();
  cpu_sequencer #(.STACK_DEPTH(SD), .WAIT_W(WW), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a mode plus the cycle position inside the current instruction
  int   m_mode = M_IDLE;
  int   m_pos = 0;
  int   m_wlen = 0;
  int   m_depth = 0;
  int   m_ret = 0;
  bit   m_halt = 1'b0;
  bit   m_ovf = 1'b0;
  bit   model_live = 1'b0;
  logic m_launch;
  logic [2:0] e_state;
  logic e_busy;

  always_comb begin
    m_launch = 1'b0;
    if (m_mode == M_IDLE || m_mode == M_HALT) m_launch = bus.run;
    else if (m_mode == M_PAUSE)               m_launch = bus.run | bus.step;
    else if (m_mode == M_RUN && m_pos == m_wlen + 2 && !m_halt && !bus.step_mode) m_launch = 1'b1;
  end

  always_comb begin
    e_state = 3'b000;
    e_busy  = (m_mode == M_RUN);
    if (m_mode == M_RUN) begin
      if (m_pos == m_wlen)          e_state = 3'b001;
      else if (m_pos == m_wlen + 1) e_state = 3'b010;
      else if (m_pos == m_wlen + 2) e_state = 3'b100;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode <= M_IDLE; m_pos <= 0; m_wlen <= 0; m_depth <= 0;
      m_ret <= 0; m_halt <= 1'b0; m_ovf <= 1'b0; model_live <= 1'b1;
    end else begin
      if (m_mode == M_RUN && m_pos == m_wlen + 2) m_ret <= (m_ret + 1) % (1 << CW);
      if (m_launch) begin
        m_mode <= M_RUN; m_pos <= 0; m_wlen <= int'(bus.mem_wait);
      end else if (m_mode == M_RUN) begin
        if (m_pos == m_wlen + 2) begin
          if (m_halt) begin m_mode <= M_HALT; m_halt <= 1'b0; end
          else m_mode <= M_PAUSE;
        end else if (m_pos == m_wlen + 1) begin
          if (bus.push && !bus.pop && m_depth == SD) begin
            m_mode <= M_FAULT; m_ovf <= 1'b1;
          end else if (bus.pop && !bus.push && m_depth == 0) begin
            m_mode <= M_FAULT; m_ovf <= 1'b0;
          end else begin
            m_depth <= m_depth + ((bus.push && !bus.pop) ? 1 : 0) - ((bus.pop && !bus.push) ? 1 : 0);
            m_pos <= m_pos + 1;
            if (bus.inst[4:1] == 4'b0100) m_halt <= 1'b1;
          end
        end else begin
          m_pos <= m_pos + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("m_state",  32'(bus.state),       32'(e_state));
      chk("m_busy",   32'(bus.busy),        32'(e_busy));
      chk("m_halted", 32'(bus.halted),      32'(m_mode == M_HALT));
      chk("m_paused", 32'(bus.paused),      32'(m_mode == M_PAUSE));
      chk("m_fault",  32'(bus.fault),       32'(m_mode == M_FAULT));
      chk("m_ovf",    32'(bus.fault_ovf),   32'(m_ovf));
      chk("m_depth",  32'(bus.stack_depth), 32'(m_depth));
      chk("m_ret",    32'(bus.retired),     32'(m_ret));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus.run = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0; bus.mem_wait = '0;
    bus.inst = 5'b00000; bus.push = 1'b0; bus.pop = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(bus.state), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_ret", 32'(bus.retired), 32'h0);
    chk("rst_depth", 32'(bus.stack_depth), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);

    // Free run, no wait states
    rst_n = 1'b1; bus.run = 1'b1; tick(); bus.run = 1'b0;
    chk("r_fetch", 32'(bus.state), 32'h1);
    tick(); chk("r_exec1", 32'(bus.state), 32'h2);
    tick(); chk("r_exec2", 32'(bus.state), 32'h4);
    tick(); chk("r_fetch2", 32'(bus.state), 32'h1);
    chk("r_ret1", 32'(bus.retired), 32'd1);
    bus.run = 1'b1; tick(); bus.run = 1'b0;
    repeat (8) tick();
    chk("r_ret4", 32'(bus.retired), 32'd4);
    chk("r_fetch5", 32'(bus.state), 32'h1);

    // Single-step
    bus.step_mode = 1'b1;
    repeat (3) tick();
    chk("s_paused", 32'(bus.paused), 32'h1);
    chk("s_ret5", 32'(bus.retired), 32'd5);
    repeat (10) tick();
    chk("s_hold_ret", 32'(bus.retired), 32'd5);
    chk("s_hold_state", 32'(bus.state), 32'h0);
    bus.step_mode = 1'b0; tick();
    chk("s_no_resume", 32'(bus.paused), 32'h1);
    bus.step_mode = 1'b1; bus.step = 1'b1; tick(); bus.step = 1'b0;
    chk("s_step_fetch", 32'(bus.state), 32'h1);
    repeat (3) tick();
    chk("s_repause", 32'(bus.paused), 32'h1);
    chk("s_ret6", 32'(bus.retired), 32'd6);

    // Wait states; mem_wait change mid-WAIT applies to the next instruction
    bus.step_mode = 1'b0; bus.mem_wait = 2'd2; bus.run = 1'b1; tick(); bus.run = 1'b0;
    chk("w2_a", 32'({bus.busy, bus.state}), 32'h8);
    bus.mem_wait = 2'd3; tick();
    chk("w2_b", 32'({bus.busy, bus.state}), 32'h8);
    tick(); chk("w2_fetch", 32'(bus.state), 32'h1);
    tick(); tick(); chk("w2_exec2", 32'(bus.state), 32'h4);
    tick(); chk("w3_a", 32'(bus.state), 32'h0);
    tick(); chk("w3_b", 32'(bus.state), 32'h0);
    tick(); chk("w3_c", 32'(bus.state), 32'h0);
    tick(); chk("w3_fetch", 32'(bus.state), 32'h1);

    // STP halt
    bus.mem_wait = 2'd0; bus.inst = 5'b01000; tick(); tick(); bus.inst = 5'b00000;
    tick();
    chk("h_halted", 32'(bus.halted), 32'h1);
    chk("h_state", 32'(bus.state), 32'h0);
    chk("h_ret8", 32'(bus.retired), 32'd8);
    bus.step = 1'b1; repeat (3) tick(); bus.step = 1'b0;
    chk("h_step_ign", 32'(bus.halted), 32'h1);
    bus.run = 1'b1; tick(); bus.run = 1'b0;
    chk("h_resume", 32'(bus.state), 32'h1);

    // Overflow
    bus.push = 1'b1; tick(); tick();
    chk("o_depth1", 32'(bus.stack_depth), 32'd1);
    n = 0;
    while (bus.fault !== 1'b1 && n < 40) begin tick(); n++; end
    chk("o_fault", 32'(bus.fault), 32'h1);
    chk("o_ovf", 32'(bus.fault_ovf), 32'h1);
    chk("o_depth4", 32'(bus.stack_depth), 32'd4);
    chk("o_state", 32'(bus.state), 32'h0);
    bus.push = 1'b0; bus.run = 1'b1; tick(); bus.run = 1'b0;
    chk("o_run_ign", 32'({bus.fault, bus.busy}), 32'h2);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("o_clr", 32'({bus.fault, bus.fault_ovf, bus.stack_depth, bus.retired}), 32'h0);

    // Underflow
    bus.run = 1'b1; bus.pop = 1'b1; tick(); bus.run = 1'b0;
    tick(); tick();
    chk("u_fault", 32'(bus.fault), 32'h1);
    chk("u_ovf", 32'(bus.fault_ovf), 32'h0);
    chk("u_depth", 32'(bus.stack_depth), 32'd0);

    // Reset in EXEC1 with push
    rst_n = 1'b0; tick(); rst_n = 1'b1; bus.pop = 1'b0;
    bus.run = 1'b1; bus.push = 1'b1; tick(); bus.run = 1'b0; tick();
    chk("x_exec1", 32'(bus.state), 32'h2);
    rst_n = 1'b0; tick(); rst_n = 1'b1; bus.push = 1'b0;
    chk("x_clr", 32'({bus.busy, bus.fault, bus.state, bus.stack_depth, bus.retired}), 32'h0);

    // push and pop together leave depth unchanged
    bus.run = 1'b1; bus.push = 1'b1; bus.pop = 1'b1; tick(); bus.run = 1'b0;
    repeat (3) tick();
    chk("pp_depth", 32'(bus.stack_depth), 32'd0);
    chk("pp_ret", 32'(bus.retired), 32'd1);
    bus.push = 1'b0; bus.pop = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
